// File: rtl/axi_err_slave.sv
// AXI4 default/error slave for the interconnect decoder miss port: accepts any
// burst, discards write data, and answers every transfer with a fixed error code.
module axi_err_slave #(
  parameter int              ID_W       = 8,
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              LEN_W      = 8,
  parameter int              SIZE_W     = 3,
  parameter logic [1:0]      RESP       = 2'b11,
  parameter logic [DATA_W-1:0] RDATA_FILL = '0,
  parameter int              CNT_W      = 16
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [SIZE_W-1:0]   AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [SIZE_W-1:0]   ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [CNT_W-1:0]    wr_err_cnt,
  output logic [CNT_W-1:0]    rd_err_cnt
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] BEAT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    else              return v + CNT_ONE;
  endfunction

  w_state_t         w_state_r, w_state_s;
  r_state_t         r_state_r, r_state_s;
  logic             en_r;
  logic [ID_W-1:0]  bid_r, rid_r;
  logic [LEN_W-1:0] len_r, beat_r;
  logic [CNT_W-1:0] wr_cnt_r, rd_cnt_r;
  logic             aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, r_last_s;
  logic             unused_s;

  // Address/size/burst fields and write payload are accepted but never used.
  assign unused_s = ^{AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB,
                      ARADDR, ARSIZE, ARBURST};

  assign AWREADY    = en_r && (w_state_r == W_IDLE);
  assign WREADY     = (w_state_r == W_DATA);
  assign BVALID     = (w_state_r == W_RESP);
  assign BID        = bid_r;
  assign BRESP      = RESP;
  assign ARREADY    = en_r && (r_state_r == R_IDLE);
  assign RVALID     = (r_state_r == R_DATA);
  assign RID        = rid_r;
  assign RDATA      = RDATA_FILL;
  assign RRESP      = RESP;
  assign r_last_s   = (r_state_r == R_DATA) && (beat_r == len_r);
  assign RLAST      = r_last_s;
  assign wr_err_cnt = wr_cnt_r;
  assign rd_err_cnt = rd_cnt_r;

  assign aw_hs_s = AWVALID && AWREADY;
  assign w_hs_s  = WVALID && WREADY;
  assign b_hs_s  = BVALID && BREADY;
  assign ar_hs_s = ARVALID && ARREADY;
  assign r_hs_s  = RVALID && RREADY;

  // Write FSM next state: a burst ends only on WLAST.
  always_comb begin
    w_state_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s)          w_state_s = W_DATA; else w_state_s = W_IDLE;
      W_DATA:  if (w_hs_s && WLAST)  w_state_s = W_RESP; else w_state_s = W_DATA;
      W_RESP:  if (b_hs_s)           w_state_s = W_IDLE; else w_state_s = W_RESP;
      default: w_state_s = W_IDLE;
    endcase
  end

  // Read FSM next state: leaves R_DATA on the accepted final beat.
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s)             r_state_s = R_DATA; else r_state_s = R_IDLE;
      R_DATA:  if (r_hs_s && r_last_s)  r_state_s = R_IDLE; else r_state_s = R_DATA;
      default: r_state_s = R_IDLE;
    endcase
  end

  // Write-side registers; en_r keeps the address channels closed for one cycle after reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      en_r      <= 1'b0;
      w_state_r <= W_IDLE;
      bid_r     <= '0;
      wr_cnt_r  <= '0;
    end else begin
      en_r      <= 1'b1;
      w_state_r <= w_state_s;
      if (aw_hs_s) bid_r <= AWID;
      if (b_hs_s)  wr_cnt_r <= sat_inc(wr_cnt_r);
    end
  end

  // Read-side registers; beat_r is LEN_W wide so the longest burst never wraps early.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state_r <= R_IDLE;
      rid_r     <= '0;
      len_r     <= '0;
      beat_r    <= '0;
      rd_cnt_r  <= '0;
    end else begin
      r_state_r <= r_state_s;
      if (ar_hs_s) begin
        rid_r  <= ARID;
        len_r  <= ARLEN;
        beat_r <= '0;
      end else if (r_hs_s && !r_last_s) begin
        beat_r <= beat_r + BEAT_ONE;
      end
      if (r_hs_s && r_last_s) rd_cnt_r <= sat_inc(rd_cnt_r);
    end
  end

endmodule
